// File: rtl/cache_way_select_pkg.sv
// Shared definitions for the 8-way tag/valid lookup stage: way geometry,
// controller state encoding and the tree pseudo-LRU victim walk.
package cache_way_select_pkg;

    localparam int WAYS   = 8;
    localparam int WAY_W  = 3;
    localparam int PLRU_W = WAYS - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_WAIT_FILL,
        ST_RESPOND
    } state_e;

    // Walk the heap from the root; a 0 bit selects the lower half, 1 the upper.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] tree);
        logic w2;
        logic w1;
        logic w0;
        w2 = tree[0];
        w1 = w2 ? tree[2] : tree[1];
        case ({w2, w1})
            2'b00:   w0 = tree[3];
            2'b01:   w0 = tree[4];
            2'b10:   w0 = tree[5];
            default: w0 = tree[6];
        endcase
        return {w2, w1, w0};
    endfunction

endpackage

// File: rtl/cache_way_select_plru.sv
// Tree pseudo-LRU access update: every node on the path to the accessed way
// is flipped to point away from it; nodes off the path are untouched.
module plru_tree_update
    import cache_way_select_pkg::*;
(
    input  logic [PLRU_W-1:0] tree_i,
    input  logic [WAY_W-1:0]  way_i,
    output logic [PLRU_W-1:0] tree_o
);

    always_comb begin
        tree_o    = tree_i;
        tree_o[0] = ~way_i[2];
        if (way_i[2]) begin
            tree_o[2] = ~way_i[1];
        end else begin
            tree_o[1] = ~way_i[1];
        end
        case (way_i[2:1])
            2'b00:   tree_o[3] = ~way_i[0];
            2'b01:   tree_o[4] = ~way_i[0];
            2'b10:   tree_o[5] = ~way_i[0];
            default: tree_o[6] = ~way_i[0];
        endcase
    end

endmodule

// File: rtl/cache_way_select.sv
// Tag compare and pseudo-LRU replacement for the 8-way data cache; drives the
// one-hot way select for the data mux and requests line fills on a miss.
module cache_way_select
    import cache_way_select_pkg::*;
#(
    parameter int SET_BITS = 5,
    parameter int TAG_W    = 20
) (
    input  logic                Clk,
    input  logic                Reset_L,
    input  logic                Req_H,
    input  logic [SET_BITS-1:0] Index,
    input  logic [TAG_W-1:0]    Tag,
    input  logic                Invalidate_H,
    input  logic                FillDone_H,
    output logic                Busy_H,
    output logic                Done_H,
    output logic                Hit_H,
    output logic [WAYS-1:0]     ValidHit_H,
    output logic                FillReq_H,
    output logic [WAY_W-1:0]    VictimWay
);

    localparam int SETS = 2 ** SET_BITS;

    state_e              state_q, state_d;
    logic                hit_q, hit_d;
    logic [WAYS-1:0]     vhit_q, vhit_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [SET_BITS-1:0] idx_q;
    logic [TAG_W-1:0]    tag_q;

    logic [TAG_W-1:0]    tag_mem [SETS][WAYS];
    logic [WAYS-1:0]     valid_q [SETS];
    logic [PLRU_W-1:0]   plru_q  [SETS];

    logic [WAYS-1:0]     hitvec;
    logic                any_hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    upd_way;
    logic [PLRU_W-1:0]   cur_tree;
    logic [PLRU_W-1:0]   next_tree;
    logic                accept;
    logic                flush;
    logic                hit_upd;
    logic                fill;

    always_comb begin
        hitvec  = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hitvec[w] = valid_q[idx_q][w] && (tag_mem[idx_q][w] == tag_q);
            if (hitvec[w]) begin
                hit_way = WAY_W'(w);
            end
        end
    end

    assign any_hit  = |hitvec;
    assign cur_tree = plru_q[idx_q];
    assign accept   = (state_q == ST_IDLE) && !Invalidate_H && Req_H;
    assign flush    = (state_q == ST_IDLE) && Invalidate_H;
    assign hit_upd  = (state_q == ST_COMPARE) && any_hit;
    assign fill     = (state_q == ST_WAIT_FILL) && FillDone_H;

    // One tree updater serves both the hit path and the fill path.
    assign upd_way = (state_q == ST_COMPARE) ? hit_way : victim_q;

    plru_tree_update u_plru (
        .tree_i (cur_tree),
        .way_i  (upd_way),
        .tree_o (next_tree)
    );

    always_comb begin
        state_d  = state_q;
        hit_d    = hit_q;
        vhit_d   = vhit_q;
        victim_d = victim_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (any_hit) begin
                    state_d = ST_RESPOND;
                    hit_d   = 1'b1;
                    vhit_d  = hitvec;
                end else begin
                    state_d  = ST_WAIT_FILL;
                    victim_d = plru_victim(cur_tree);
                end
            end
            ST_WAIT_FILL: begin
                if (FillDone_H) begin
                    state_d = ST_RESPOND;
                    hit_d   = 1'b0;
                    vhit_d  = {{(WAYS-1){1'b0}}, 1'b1} << victim_q;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
                hit_d   = 1'b0;
                vhit_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_L) begin
            state_q  <= ST_IDLE;
            hit_q    <= 1'b0;
            vhit_q   <= '0;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            hit_q    <= hit_d;
            vhit_q   <= vhit_d;
            victim_q <= victim_d;
            if (flush) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                end
            end else if (fill) begin
                valid_q[idx_q][victim_q] <= 1'b1;
            end
            if (hit_upd || fill) begin
                plru_q[idx_q] <= next_tree;
            end
        end
    end

    // Tag storage and the captured request carry no reset; valid bits gate them.
    always_ff @(posedge Clk) begin
        if (accept) begin
            idx_q <= Index;
            tag_q <= Tag;
        end
        if (fill) begin
            tag_mem[idx_q][victim_q] <= tag_q;
        end
    end

    assign Busy_H     = (state_q != ST_IDLE);
    assign Done_H     = (state_q == ST_RESPOND);
    assign FillReq_H  = (state_q == ST_WAIT_FILL);
    assign Hit_H      = hit_q;
    assign ValidHit_H = vhit_q;
    assign VictimWay  = victim_q;

endmodule

// File: tb/tb_cache_way_select.sv
// Bench for cache_way_select: directed scenarios plus randomized traffic checked
// against a set-associative cache model with a heap-walk pseudo-LRU.
module tb_cache_way_select;

    logic        Clk = 1'b0;
    logic        Reset_L;
    logic        Req_H;
    logic [4:0]  Index;
    logic [19:0] Tag;
    logic        Invalidate_H;
    logic        FillDone_H;
    logic        Busy_H;
    logic        Done_H;
    logic        Hit_H;
    logic [7:0]  ValidHit_H;
    logic        FillReq_H;
    logic [2:0]  VictimWay;

    cache_way_select #(.SET_BITS(5), .TAG_W(20)) dut (
        .Clk          (Clk),
        .Reset_L      (Reset_L),
        .Req_H        (Req_H),
        .Index        (Index),
        .Tag          (Tag),
        .Invalidate_H (Invalidate_H),
        .FillDone_H   (FillDone_H),
        .Busy_H       (Busy_H),
        .Done_H       (Done_H),
        .Hit_H        (Hit_H),
        .ValidHit_H   (ValidHit_H),
        .FillReq_H    (FillReq_H),
        .VictimWay    (VictimWay)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit         hit;
        logic [7:0] vh;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    bit          mvalid [32][8];
    logic [19:0] mtag   [32][8];
    bit          mtree  [32][7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 32; s++) begin
            for (int w = 0; w < 8; w++) mvalid[s][w] = 1'b0;
            for (int n = 0; n < 7; n++) mtree[s][n] = 1'b0;
        end
    endtask

    function automatic int model_victim(input int s);
        int node = 0;
        int way  = 0;
        for (int lvl = 0; lvl < 3; lvl++) begin
            int b = int'(mtree[s][node]);
            way  = way * 2 + b;
            node = 2 * node + 1 + b;
        end
        return way;
    endfunction

    task automatic model_touch(input int s, input int way);
        int node = 0;
        for (int lvl = 2; lvl >= 0; lvl--) begin
            int b = (way >> lvl) & 1;
            mtree[s][node] = (b == 0);
            node = 2 * node + 1 + b;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_L = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_L = 1'b1;
        model_reset();
        exp_q.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy_H && n < 64) begin
            @(negedge Clk);
            n++;
        end
        if (Busy_H) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout: Busy_H still 1 after %0d cycles", n);
        end
    endtask

    // Issues one lookup, services the fill if the model predicts a miss,
    // and returns the victim way seen on the port (-1 for a hit).
    task automatic issue(input int s, input logic [19:0] tg, input bit poke, output int vic);
        int   hway = -1;
        int   mway;
        int   nwait;
        exp_t e;
        wait_idle();
        for (int w = 0; w < 8; w++) begin
            if (mvalid[s][w] && mtag[s][w] == tg) hway = w;
        end
        mway  = (hway >= 0) ? hway : model_victim(s);
        e.hit = (hway >= 0);
        e.vh  = 8'(1 << mway);
        exp_q.push_back(e);
        Req_H = 1'b1;
        Index = 5'(s);
        Tag   = tg;
        @(posedge Clk); #1;
        Req_H = 1'b0;
        chk("busy_after_req", 32'(Busy_H), 32'd1);
        if (hway >= 0) begin
            vic = -1;
            model_touch(s, hway);
            @(posedge Clk); #1;
            chk("hit_done_latency", 32'(Done_H), 32'd1);
            chk("hit_no_fillreq", 32'(FillReq_H), 32'd0);
        end else begin
            @(posedge Clk); #1;
            chk("fillreq_up", 32'(FillReq_H), 32'd1);
            chk("victim_way", 32'(VictimWay), 32'(mway));
            vic   = int'(VictimWay);
            nwait = int'($urandom_range(0, 3)) + (poke ? 1 : 0);
            for (int k = 0; k < nwait; k++) begin
                @(negedge Clk);
                if (poke) begin
                    Req_H = 1'b1;
                    Index = 5'($urandom);
                    Tag   = 20'($urandom);
                end
                @(posedge Clk); #1;
                chk("victim_stable", 32'(VictimWay), 32'(mway));
                chk("fillreq_held", 32'(FillReq_H), 32'd1);
            end
            @(negedge Clk);
            Req_H      = 1'b0;
            FillDone_H = 1'b1;
            @(posedge Clk); #1;
            FillDone_H = 1'b0;
            chk("miss_done_latency", 32'(Done_H), 32'd1);
            chk("fillreq_drop", 32'(FillReq_H), 32'd0);
            mtag[s][mway]   = tg;
            mvalid[s][mway] = 1'b1;
            model_touch(s, mway);
        end
        @(negedge Clk);
    endtask

    task automatic invalidate(input bit with_req);
        wait_idle();
        Invalidate_H = 1'b1;
        Req_H        = with_req;
        Index        = 5'($urandom);
        Tag          = 20'($urandom);
        @(posedge Clk); #1;
        Invalidate_H = 1'b0;
        Req_H        = 1'b0;
        for (int s = 0; s < 32; s++) begin
            for (int w = 0; w < 8; w++) mvalid[s][w] = 1'b0;
        end
        chk("inv_stays_idle", 32'(Busy_H), 32'd0);
        @(negedge Clk);
    endtask

    always @(negedge Clk) begin
        if (Done_H) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: Hit_H=%0b ValidHit_H=0x%02h with nothing pending", Hit_H, ValidHit_H);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_hit", 32'(Hit_H), 32'(mon_e.hit));
                chk("resp_validhit", 32'(ValidHit_H), 32'(mon_e.vh));
                chk("resp_onehot", 32'($onehot(ValidHit_H)), 32'd1);
            end
        end else if (ValidHit_H != 8'h00) begin
            checks++;
            failures++;
            $display("FAIL validhit_outside_done: got 0x%02h expected 0x00", ValidHit_H);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vic;
        int seq[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        Reset_L      = 1'b0;
        Req_H        = 1'b0;
        Index        = '0;
        Tag          = '0;
        Invalidate_H = 1'b0;
        FillDone_H   = 1'b0;
        model_reset();
        do_reset();
        chk("rst_busy", 32'(Busy_H), 32'd0);
        chk("rst_done", 32'(Done_H), 32'd0);
        chk("rst_hit", 32'(Hit_H), 32'd0);
        chk("rst_fillreq", 32'(FillReq_H), 32'd0);
        chk("rst_validhit", 32'(ValidHit_H), 32'd0);
        chk("rst_victim", 32'(VictimWay), 32'd0);

        // First miss then re-hit of the same line.
        issue(3, 20'h00012, 1'b0, vic);
        chk("first_miss_victim", 32'(vic), 32'd0);
        issue(3, 20'h00012, 1'b0, vic);

        // Victim order from a clean tree, then the 9th replacement.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue(3, 20'h00100 + 20'(i), 1'b0, vic);
            chk("plru_sequence", 32'(vic), 32'(seq[i]));
        end
        issue(3, 20'h00200, 1'b0, vic);
        chk("ninth_victim", 32'(vic), 32'd0);

        do_reset();
        for (int i = 0; i < 8; i++) issue(3, 20'h00100 + 20'(i), 1'b0, vic);
        issue(3, 20'h00100, 1'b0, vic);
        issue(3, 20'h00300, 1'b0, vic);
        chk("victim_after_rehit", 32'(vic), 32'd4);

        // Invalidate beats a simultaneous request; the tree survives it.
        do_reset();
        issue(3, 20'h00012, 1'b0, vic);
        invalidate(1'b1);
        repeat (3) begin
            @(posedge Clk); #1;
            chk("inv_req_dropped", 32'(Done_H | Busy_H), 32'd0);
        end
        @(negedge Clk);
        issue(3, 20'h00012, 1'b0, vic);
        chk("inv_plru_kept", 32'(vic), 32'd4);

        // Reset while waiting for a fill, followed by a stray FillDone.
        do_reset();
        Req_H = 1'b1;
        Index = 5'd5;
        Tag   = 20'h00777;
        @(posedge Clk); #1;
        Req_H = 1'b0;
        @(posedge Clk); #1;
        chk("abort_fillreq_up", 32'(FillReq_H), 32'd1);
        @(negedge Clk);
        Reset_L = 1'b0;
        @(posedge Clk); #1;
        chk("abort_busy", 32'(Busy_H), 32'd0);
        chk("abort_fillreq", 32'(FillReq_H), 32'd0);
        @(negedge Clk);
        Reset_L = 1'b1;
        model_reset();
        FillDone_H = 1'b1;
        @(posedge Clk); #1;
        FillDone_H = 1'b0;
        repeat (3) begin
            @(posedge Clk); #1;
            chk("stray_filldone_ignored", 32'(Done_H | Busy_H), 32'd0);
        end
        @(negedge Clk);

        // Same tag in two sets lands in different ways; Req during busy is ignored.
        issue(3, 20'h00055, 1'b0, vic);
        issue(4, 20'h00066, 1'b0, vic);
        issue(4, 20'h00055, 1'b1, vic);
        chk("set4_second_victim", 32'(vic), 32'd4);
        issue(3, 20'h00055, 1'b0, vic);
        issue(4, 20'h00055, 1'b0, vic);

        // Randomized traffic over a few sets with more tags than ways.
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                invalidate(1'($urandom_range(0, 1)));
            end else begin
                issue(int'($urandom_range(0, 3)), 20'($urandom_range(0, 10)),
                      ($urandom_range(0, 3) == 0), vic);
            end
        end

        repeat (4) @(negedge Clk);
        chk("responses_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
